// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg
//   Shared definitions for the instruction fetch stage: FSM state encodings,
//   fetch fault cause codes and the NOP instruction word presented after reset.
package fetch_unit_pkg;

   typedef enum logic [1:0] {
      FETCH_IDLE = 2'd0,
      FETCH_REQ  = 2'd1,
      FETCH_DONE = 2'd2
   } fetch_state_t;

   localparam logic [1:0] FETCH_FAULT_NONE       = 2'd0;
   localparam logic [1:0] FETCH_FAULT_MISALIGNED = 2'd1;
   localparam logic [1:0] FETCH_FAULT_ACCESS     = 2'd2;
   localparam logic [1:0] FETCH_FAULT_TIMEOUT    = 2'd3;

   // addi x0, x0, 0
   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/fetch_unit.sv
// fetch_unit
//   Instruction fetch stage of the multi-cycle RV32 core. A fetch pulse in IDLE
//   issues one 32-bit read on the instruction bus (sequential PC or redirect
//   target), the returned word is latched and presented with its PC to the
//   decoder for one cycle. Misaligned targets, bus errors and bus timeouts are
//   reported as one-cycle fault pulses with a held cause and address.
//
// Ports
//   I_clk, I_reset            clock, synchronous active-high reset
//   I_fetch, I_redirect,      fetch request from control; redirect selects
//   I_target                  I_target instead of the sequential PC
//   O_bus_req, O_bus_addr     read request / word address, held until done
//   I_bus_ack, I_bus_err,     bus response: data valid / error / read data
//   I_bus_data
//   O_instr, O_pc             last fetched word and its address
//   O_instr_valid             one-cycle pulse when O_instr/O_pc are new
//   O_busy                    high whenever not IDLE
//   O_fault, O_fault_cause,   one-cycle fault pulse; cause and address are
//   O_fault_addr              held until the next fault or reset
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter logic [31:0] RESET_PC       = 32'h0000_0000,
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        I_clk,
   input  logic        I_reset,
   input  logic        I_fetch,
   input  logic        I_redirect,
   input  logic [31:0] I_target,
   output logic        O_bus_req,
   output logic [31:0] O_bus_addr,
   input  logic        I_bus_ack,
   input  logic        I_bus_err,
   input  logic [31:0] I_bus_data,
   output logic [31:0] O_instr,
   output logic [31:0] O_pc,
   output logic        O_instr_valid,
   output logic        O_busy,
   output logic        O_fault,
   output logic [1:0]  O_fault_cause,
   output logic [31:0] O_fault_addr
);

   // Timer value in the last cycle the request may stay outstanding; with the
   // timer cleared on entry to REQ this keeps O_bus_req high TIMEOUT_CYCLES cycles.
   localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT_CYCLES - 1);

   fetch_state_t state_reg, state_next;
   logic [31:0]  fetch_pc_reg, fetch_pc_next;
   logic [31:0]  instr_reg, instr_next;
   logic [31:0]  pc_reg, pc_next;
   logic         bus_req_reg, bus_req_next;
   logic [31:0]  bus_addr_reg, bus_addr_next;
   logic         fault_reg, fault_next;
   logic [1:0]   cause_reg, cause_next;
   logic [31:0]  fault_addr_reg, fault_addr_next;
   logic [7:0]   timer_reg, timer_next;
   logic [31:0]  fetch_addr;

   always_ff @(posedge I_clk) begin
      if (I_reset) begin
         state_reg      <= FETCH_IDLE;
         fetch_pc_reg   <= RESET_PC;
         instr_reg      <= NOP_INSTR;
         pc_reg         <= RESET_PC;
         bus_req_reg    <= 1'b0;
         bus_addr_reg   <= 32'h0;
         fault_reg      <= 1'b0;
         cause_reg      <= FETCH_FAULT_NONE;
         fault_addr_reg <= 32'h0;
         timer_reg      <= 8'h0;
      end else begin
         state_reg      <= state_next;
         fetch_pc_reg   <= fetch_pc_next;
         instr_reg      <= instr_next;
         pc_reg         <= pc_next;
         bus_req_reg    <= bus_req_next;
         bus_addr_reg   <= bus_addr_next;
         fault_reg      <= fault_next;
         cause_reg      <= cause_next;
         fault_addr_reg <= fault_addr_next;
         timer_reg      <= timer_next;
      end
   end

   always_comb begin
      state_next      = state_reg;
      fetch_pc_next   = fetch_pc_reg;
      instr_next      = instr_reg;
      pc_next         = pc_reg;
      bus_req_next    = bus_req_reg;
      bus_addr_next   = bus_addr_reg;
      fault_next      = 1'b0;
      cause_next      = cause_reg;
      fault_addr_next = fault_addr_reg;
      timer_next      = timer_reg;
      fetch_addr      = I_redirect ? I_target : fetch_pc_reg;

      case (state_reg)
         FETCH_IDLE: begin
            if (I_fetch) begin
               if (fetch_addr[1:0] != 2'b00) begin
                  // Misaligned target never reaches the bus.
                  fault_next      = 1'b1;
                  cause_next      = FETCH_FAULT_MISALIGNED;
                  fault_addr_next = fetch_addr;
               end else begin
                  state_next    = FETCH_REQ;
                  bus_req_next  = 1'b1;
                  bus_addr_next = fetch_addr;
                  timer_next    = 8'h0;
               end
            end
         end

         FETCH_REQ: begin
            timer_next = timer_reg + 8'd1;
            // Error has priority over a simultaneous ack; a response in the
            // last allowed cycle still beats the timeout.
            if (I_bus_err) begin
               state_next      = FETCH_IDLE;
               bus_req_next    = 1'b0;
               fault_next      = 1'b1;
               cause_next      = FETCH_FAULT_ACCESS;
               fault_addr_next = bus_addr_reg;
            end else if (I_bus_ack) begin
               state_next    = FETCH_DONE;
               bus_req_next  = 1'b0;
               instr_next    = I_bus_data;
               pc_next       = bus_addr_reg;
               fetch_pc_next = bus_addr_reg + 32'd4;
            end else if (timer_reg == TIMER_LAST) begin
               state_next      = FETCH_IDLE;
               bus_req_next    = 1'b0;
               fault_next      = 1'b1;
               cause_next      = FETCH_FAULT_TIMEOUT;
               fault_addr_next = bus_addr_reg;
            end
         end

         FETCH_DONE: begin
            state_next = FETCH_IDLE;
         end

         default: begin
            state_next = FETCH_IDLE;
         end
      endcase
   end

   assign O_bus_req     = bus_req_reg;
   assign O_bus_addr    = bus_addr_reg;
   assign O_instr       = instr_reg;
   assign O_pc          = pc_reg;
   assign O_instr_valid = (state_reg == FETCH_DONE);
   assign O_busy        = (state_reg != FETCH_IDLE);
   assign O_fault       = fault_reg;
   assign O_fault_cause = cause_reg;
   assign O_fault_addr  = fault_addr_reg;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit
//   Scoreboard bench for fetch_unit. The driver acts as control sequencer and
//   bus slave, keeps a transaction-level model of the fetch PC and held
//   outputs, and queues the expected decoder/trap event of each fetch. The
//   monitor pops and compares whenever the DUT pulses O_instr_valid or O_fault.
module tb_fetch_unit;

   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam int          TMO      = 4;
   localparam logic [31:0] NOP      = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        I_reset, I_fetch, I_redirect, I_bus_ack, I_bus_err;
   logic [31:0] I_target, I_bus_data;
   logic        O_bus_req, O_instr_valid, O_busy, O_fault;
   logic [31:0] O_bus_addr, O_instr, O_pc, O_fault_addr;
   logic [1:0]  O_fault_cause;

   fetch_unit #(.RESET_PC(RESET_PC), .TIMEOUT_CYCLES(TMO)) dut (
      .I_clk(clk), .I_reset(I_reset), .I_fetch(I_fetch), .I_redirect(I_redirect),
      .I_target(I_target), .O_bus_req(O_bus_req), .O_bus_addr(O_bus_addr),
      .I_bus_ack(I_bus_ack), .I_bus_err(I_bus_err), .I_bus_data(I_bus_data),
      .O_instr(O_instr), .O_pc(O_pc), .O_instr_valid(O_instr_valid),
      .O_busy(O_busy), .O_fault(O_fault), .O_fault_cause(O_fault_cause),
      .O_fault_addr(O_fault_addr)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit          is_fault;
      logic [31:0] instr;
      logic [31:0] pc;
      logic [1:0]  cause;
      logic [31:0] faddr;
   } exp_t;

   exp_t sb_q[$];

   // Transaction-level model state
   logic [31:0] m_fetch_pc, m_instr, m_pc, m_faddr;
   logic [1:0]  m_cause;

   // Per-cycle expectations written by the driver, checked by the monitor
   bit          mon_en = 0, chk_reset = 0, chk_end = 0;
   bit          exp_req = 0, exp_busy = 0;
   logic [31:0] exp_addr = 0;

   int tests = 0;
   int fails = 0;

   function automatic void check(string name, logic [31:0] act, logic [31:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
      end
   endfunction

   // Monitor / scoreboard
   always @(negedge clk) begin
      if (mon_en) begin
         exp_t e;
         check("valid_fault_excl", {31'h0, O_instr_valid & O_fault}, 32'h0);
         check("bus_req", {31'h0, O_bus_req}, {31'h0, exp_req});
         if (exp_req) check("bus_addr", O_bus_addr, exp_addr);
         check("busy", {31'h0, O_busy}, {31'h0, exp_busy});
         if (chk_reset) begin
            check("rst_instr", O_instr, NOP);
            check("rst_pc", O_pc, RESET_PC);
            check("rst_cause", {30'h0, O_fault_cause}, 32'h0);
            check("rst_faddr", O_fault_addr, 32'h0);
            check("rst_bus_addr", O_bus_addr, 32'h0);
            check("rst_valid", {31'h0, O_instr_valid}, 32'h0);
            check("rst_fault", {31'h0, O_fault}, 32'h0);
         end
         if (O_instr_valid || O_fault) begin
            if (sb_q.size() == 0) begin
               check("unexpected_pulse", {31'h0, O_fault}, 32'hFFFF_FFFF);
            end else begin
               e = sb_q.pop_front();
               check("event_is_fault", {31'h0, O_fault}, {31'h0, e.is_fault});
               check("instr", O_instr, e.instr);
               check("pc", O_pc, e.pc);
               check("fault_cause", {30'h0, O_fault_cause}, {30'h0, e.cause});
               check("fault_addr", O_fault_addr, e.faddr);
            end
         end
         if (chk_end) check("queue_empty", sb_q.size(), 32'h0);
      end
   end

   task automatic do_reset();
      I_reset = 1'b1;
      @(posedge clk); #1;
      I_reset    = 1'b0;
      mon_en     = 1'b1;
      chk_reset  = 1'b1;
      exp_req    = 1'b0;
      exp_busy   = 1'b0;
      m_fetch_pc = RESET_PC;
      m_instr    = NOP;
      m_pc       = RESET_PC;
      m_cause    = 2'd0;
      m_faddr    = 32'h0;
      @(posedge clk); #1;
      chk_reset = 1'b0;
   endtask

   // One fetch. mode: 0 ack, 1 err, 2 ack+err. wait_cyc >= TMO means the
   // slave stays silent. Called and returns at 1 time unit after a posedge.
   task automatic do_fetch(input bit redir, input logic [31:0] tgt, input int wait_cyc,
                           input int mode, input logic [31:0] data, input bit late_ack);
      logic [31:0] addr;
      bit          done;
      bit          ok;
      addr = redir ? tgt : m_fetch_pc;
      I_fetch = 1'b1; I_redirect = redir; I_target = tgt;
      exp_req = 1'b0; exp_busy = 1'b0;
      @(posedge clk); #1;
      I_fetch = 1'b0; I_redirect = 1'b0; I_target = $urandom;
      if (addr[1:0] != 2'b00) begin
         sb_q.push_back('{is_fault: 1'b1, instr: m_instr, pc: m_pc, cause: 2'd1, faddr: addr});
         m_cause = 2'd1; m_faddr = addr;
         @(posedge clk); #1;
         return;
      end
      done = 1'b0;
      ok   = 1'b0;
      for (int i = 0; i < TMO && !done; i++) begin
         exp_req = 1'b1; exp_busy = 1'b1; exp_addr = addr;
         // Fetch requests while busy must be ignored.
         I_fetch = 1'($urandom_range(0, 1)); I_redirect = 1'($urandom_range(0, 1));
         I_target = $urandom;
         if (i == wait_cyc) begin
            I_bus_ack = (mode != 1); I_bus_err = (mode != 0); I_bus_data = data;
            done = 1'b1;
            if (mode == 0) begin
               ok = 1'b1;
               sb_q.push_back('{is_fault: 1'b0, instr: data, pc: addr, cause: m_cause, faddr: m_faddr});
               m_instr = data; m_pc = addr; m_fetch_pc = addr + 32'd4;
            end else begin
               sb_q.push_back('{is_fault: 1'b1, instr: m_instr, pc: m_pc, cause: 2'd2, faddr: addr});
               m_cause = 2'd2; m_faddr = addr;
            end
         end else begin
            I_bus_data = $urandom;
         end
         @(posedge clk); #1;
         I_bus_ack = 1'b0; I_bus_err = 1'b0; I_fetch = 1'b0; I_redirect = 1'b0;
      end
      if (!done) begin
         sb_q.push_back('{is_fault: 1'b1, instr: m_instr, pc: m_pc, cause: 2'd3, faddr: addr});
         m_cause = 2'd3; m_faddr = addr;
         if (late_ack) begin
            I_bus_ack = 1'b1; I_bus_data = $urandom;
         end
      end
      exp_req = 1'b0; exp_busy = ok;
      @(posedge clk); #1;
      I_bus_ack = 1'b0;
      exp_busy  = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [31:0] r;
      I_reset = 1'b1; I_fetch = 1'b0; I_redirect = 1'b0; I_target = 32'h0;
      I_bus_ack = 1'b0; I_bus_err = 1'b0; I_bus_data = 32'h0;
      @(posedge clk); #1;
      do_reset();

      // Directed cases
      do_fetch(1'b0, 32'h0, 0, 0, 32'h0050_0093, 1'b0);   // addr 0, zero-wait
      do_fetch(1'b0, 32'h0, 0, 0, 32'h1234_5678, 1'b0);   // sequential addr 4
      do_fetch(1'b1, 32'h0000_0102, 0, 0, 32'h0, 1'b0);   // misaligned
      do_fetch(1'b0, 32'h0, 3, 2, 32'hDEAD_BEEF, 1'b0);   // ack+err after 3 waits
      do_fetch(1'b0, 32'h0, 9, 0, 32'h0, 1'b1);           // timeout, late ack
      do_fetch(1'b0, 32'h0, 1, 0, 32'hCAFE_0001, 1'b0);   // still addr 8

      // Reset while the request is outstanding
      I_fetch = 1'b1; I_redirect = 1'b1; I_target = 32'h0000_0040;
      @(posedge clk); #1;
      I_fetch = 1'b0; I_redirect = 1'b0;
      exp_req = 1'b1; exp_busy = 1'b1; exp_addr = 32'h0000_0040;
      @(posedge clk); #1;
      do_reset();
      do_fetch(1'b0, 32'h0, 0, 0, 32'hAAAA_5555, 1'b0);   // back at RESET_PC

      // Address wrap
      do_fetch(1'b1, 32'hFFFF_FFFC, 0, 0, 32'h0000_0113, 1'b0);
      do_fetch(1'b0, 32'h0, 2, 0, 32'h0000_0213, 1'b0);   // addr 0

      // Randomized traffic
      for (int n = 0; n < 200; n++) begin
         r = $urandom;
         if ($urandom_range(0, 3) == 0) r[1:0] = 2'($urandom_range(1, 3));
         else r[1:0] = 2'b00;
         do_fetch(1'($urandom_range(0, 1)), r, $urandom_range(0, 5),
                  $urandom_range(0, 2), $urandom, 1'($urandom_range(0, 1)));
         if ($urandom_range(0, 4) == 0) begin
            @(posedge clk); #1;
         end
      end

      chk_end = 1'b1;
      @(posedge clk); #1;
      chk_end = 1'b0;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
